// File: rtl/spi_cmd_pkg.sv
// Shared types and defaults for the SPI command-to-Wishbone bridge.
// Holds the command op encoding, the FSM state encoding and small decode helpers.
package spi_cmd_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 17;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_WRITE_AT   = 2'b00,
    OP_READ_AT    = 2'b01,
    OP_WRITE_NEXT = 2'b10,
    OP_READ_NEXT  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_BUS     = 3'd4
  } state_e;

  function automatic logic op_is_write(input op_e op);
    return (op == OP_WRITE_AT) || (op == OP_WRITE_NEXT);
  endfunction

  function automatic logic op_has_addr(input op_e op);
    return (op == OP_WRITE_AT) || (op == OP_READ_AT);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// RESET_VAL selects the value both flops hold while reset is asserted.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/spi_cmd.sv
// SPI command decoder: turns received SPI byte sequences into single Wishbone
// master cycles (pipelined stall/ack handshake), one cycle per command.
module spi_cmd
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spi_cs_ni,
  input  logic [DATA_WIDTH-1:0] spi_rx_data_i,
  input  logic                  spi_rx_strobe_i,
  output logic [DATA_WIDTH-1:0] spi_tx_data_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i
);

  logic cs_sync;
  logic strobe_sync;
  logic strobe_prev_reg;
  logic byte_valid;

  // CS idles high so a reset never looks like the middle of a frame.
  sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .din   (spi_cs_ni),
    .dout  (cs_sync)
  );

  sync2 #(.RESET_VAL(1'b0)) u_sync_strobe (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .din   (spi_rx_strobe_i),
    .dout  (strobe_sync)
  );

  assign byte_valid = strobe_sync & ~strobe_prev_reg;

  state_e                  state_reg,   state_next;
  op_e                     op_reg,      op_next;
  logic                    addr16_reg,  addr16_next;
  logic [7:0]              addr_hi_reg, addr_hi_next;
  logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
  logic [DATA_WIDTH-1:0]   data_reg,    data_next;
  logic [DATA_WIDTH-1:0]   tx_reg,      tx_next;
  logic                    cyc_reg,     cyc_next;
  logic                    stb_reg,     stb_next;
  logic                    we_reg,      we_next;
  logic                    overrun_reg, overrun_next;
  logic                    start_bus;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_prev_reg <= 1'b0;
      state_reg       <= ST_CMD;
      op_reg          <= OP_WRITE_AT;
      addr16_reg      <= 1'b0;
      addr_hi_reg     <= '0;
      addr_reg        <= '0;
      data_reg        <= '0;
      tx_reg          <= '0;
      cyc_reg         <= 1'b0;
      stb_reg         <= 1'b0;
      we_reg          <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      strobe_prev_reg <= strobe_sync;
      state_reg       <= state_next;
      op_reg          <= op_next;
      addr16_reg      <= addr16_next;
      addr_hi_reg     <= addr_hi_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
      tx_reg          <= tx_next;
      cyc_reg         <= cyc_next;
      stb_reg         <= stb_next;
      we_reg          <= we_next;
      overrun_reg     <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    addr16_next  = addr16_reg;
    addr_hi_next = addr_hi_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    tx_next      = tx_reg;
    cyc_next     = cyc_reg;
    stb_next     = stb_reg;
    we_next      = we_reg;
    overrun_next = overrun_reg;
    start_bus    = 1'b0;

    if (cs_sync) begin
      overrun_next = 1'b0;
    end

    // Address bytes are staged and only committed on the last one, so a
    // command cut short by CS leaves the running address untouched.
    unique case (state_reg)
      ST_CMD: begin
        if (!cs_sync && byte_valid) begin
          op_next = op_e'(spi_rx_data_i[7:6]);
          if (op_has_addr(op_next)) begin
            addr16_next = spi_rx_data_i[0];
            state_next  = ST_ADDR_HI;
          end else if (op_next == OP_WRITE_NEXT) begin
            state_next = ST_DATA;
          end else begin
            state_next = ST_BUS;
            start_bus  = 1'b1;
          end
        end
      end
      ST_ADDR_HI: begin
        if (cs_sync) begin
          state_next = ST_CMD;
        end else if (byte_valid) begin
          addr_hi_next = spi_rx_data_i[7:0];
          state_next   = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (cs_sync) begin
          state_next = ST_CMD;
        end else if (byte_valid) begin
          addr_next = ADDR_WIDTH'({addr16_reg, addr_hi_reg, spi_rx_data_i[7:0]});
          if (op_reg == OP_WRITE_AT) begin
            state_next = ST_DATA;
          end else begin
            state_next = ST_BUS;
            start_bus  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (cs_sync) begin
          state_next = ST_CMD;
        end else if (byte_valid) begin
          data_next  = spi_rx_data_i;
          state_next = ST_BUS;
          start_bus  = 1'b1;
        end
      end
      ST_BUS: begin
        // CS is deliberately ignored here: a started cycle always completes.
        if (byte_valid) begin
          overrun_next = 1'b1;
        end
        if (stb_reg && !wb_stall_i) begin
          stb_next = 1'b0;
        end
        if (wb_ack_i) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          addr_next  = addr_reg + ADDR_WIDTH'(1);
          state_next = ST_CMD;
          if (!we_reg) begin
            tx_next = wb_dat_i;
          end
        end
      end
      default: state_next = ST_CMD;
    endcase

    if (start_bus) begin
      cyc_next = 1'b1;
      stb_next = 1'b1;
      we_next  = op_is_write(op_next);
    end
  end

  assign spi_tx_data_o = tx_reg;
  assign busy_o        = (state_reg == ST_BUS);
  assign overrun_o     = overrun_reg;
  assign wb_cyc_o      = cyc_reg;
  assign wb_stb_o      = stb_reg;
  assign wb_we_o       = we_reg;
  assign wb_adr_o      = addr_reg;
  assign wb_dat_o      = data_reg;

endmodule

// File: tb/tb_spi_cmd.sv
// Randomized scoreboard bench for spi_cmd: stimulus queues expected bus cycles
// from an address/command model; a monitor checks each Wishbone cycle.
module tb_spi_cmd;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spi_cs_ni = 1'b1;
  logic [7:0]  spi_rx_data_i = '0;
  logic        spi_rx_strobe_i = 1'b0;
  logic [7:0]  spi_tx_data_o;
  logic        busy_o;
  logic        overrun_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [16:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_cmd dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .spi_cs_ni       (spi_cs_ni),
    .spi_rx_data_i   (spi_rx_data_i),
    .spi_rx_strobe_i (spi_rx_strobe_i),
    .spi_tx_data_o   (spi_tx_data_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_we_o         (wb_we_o),
    .wb_adr_o        (wb_adr_o),
    .wb_dat_o        (wb_dat_o),
    .wb_dat_i        (wb_dat_i),
    .wb_ack_i        (wb_ack_i),
    .wb_stall_i      (wb_stall_i)
  );

  typedef struct {
    bit          we;
    logic [16:0] adr;
    logic [7:0]  dat;
    int          stall;
    logic [7:0]  rdata;
  } exp_item_t;

  exp_item_t   exp_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [16:0] model_addr = '0;
  int          stall_cfg = 0;
  int          ack_cfg = 0;
  logic [7:0]  rdata_cfg = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wishbone slave: stalls stall_cfg clocks, acks ack_cfg clocks after accept.
  initial begin : responder
    int r_state = 0;
    int stall_left = 0;
    int ack_left = 0;
    forever begin
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      if (!rst_ni) begin
        r_state = 0;
        wb_stall_i = 1'b0;
      end else begin
        if (r_state == 3) r_state = 0;
        if (r_state == 0 && wb_cyc_o && wb_stb_o) begin
          stall_left = stall_cfg;
          ack_left = ack_cfg;
          r_state = 1;
        end
        if (r_state == 1) begin
          if (stall_left > 0) begin
            wb_stall_i = 1'b1;
            stall_left--;
          end else begin
            wb_stall_i = 1'b0;
            if (ack_left == 0) begin
              wb_ack_i = 1'b1;
              wb_dat_i = rdata_cfg;
              r_state = 3;
            end else begin
              r_state = 2;
            end
          end
        end else if (r_state == 2) begin
          ack_left--;
          if (ack_left == 0) begin
            wb_ack_i = 1'b1;
            wb_dat_i = rdata_cfg;
            r_state = 3;
          end
        end
      end
    end
  end

  // Monitor: samples just after each rising edge; prev_* hold pre-edge outputs.
  initial begin : monitor
    exp_item_t  cur;
    bit         in_txn = 0;
    bit         accepted = 0;
    int         stb_cnt = 0;
    bit         prev_cyc = 0;
    bit         prev_stb = 0;
    logic [7:0] exp_tx = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        in_txn = 0;
        exp_tx = '0;
        prev_cyc = 0;
        prev_stb = 0;
      end else begin
        if (wb_cyc_o && !prev_cyc) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cycle", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            in_txn = 1;
            accepted = 0;
            stb_cnt = 0;
            chk("adr", int'(wb_adr_o), int'(cur.adr));
            chk("we", int'(wb_we_o), int'(cur.we));
            if (cur.we) chk("dat", int'(wb_dat_o), int'(cur.dat));
            chk("stb_with_cyc", int'(wb_stb_o), 1);
            chk("busy_in_bus", int'(busy_o), 1);
          end
        end else if (in_txn) begin
          if (prev_stb) stb_cnt++;
          if (prev_stb && !wb_stall_i && !accepted) begin
            accepted = 1;
            chk("stb_clks", stb_cnt, cur.stall + 1);
            chk("stb_drop", int'(wb_stb_o), 0);
          end
          if (wb_ack_i) begin
            chk("cyc_drop", int'(wb_cyc_o), 0);
            chk("busy_drop", int'(busy_o), 0);
            if (!cur.we) exp_tx = cur.rdata;
            chk("tx_data", int'(spi_tx_data_o), int'(exp_tx));
            in_txn = 0;
          end else begin
            chk("cyc_hold", int'(wb_cyc_o), 1);
          end
        end
        prev_cyc = wb_cyc_o;
        prev_stb = wb_stb_o;
      end
    end
  end

  // SCK period of 6 clk: strobe high 3 clk, low 3 clk, data held throughout.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    spi_rx_data_i = b;
    spi_rx_strobe_i = 1'b1;
    repeat (3) @(negedge clk_i);
    spi_rx_strobe_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_timeout", int'(busy_o), 0);
  endtask

  task automatic start_frame();
    @(negedge clk_i);
    spi_cs_ni = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic end_frame(input bit exp_ovr);
    chk("overrun_in_frame", int'(overrun_o), int'(exp_ovr));
    spi_cs_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("overrun_after_cs", int'(overrun_o), 0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [16:0] adr, input logic [7:0] data,
                          input int stall, input int ackd, input logic [7:0] rdata,
                          input bit do_wait);
    exp_item_t  it;
    logic [7:0] cmd;
    bit         has_addr;
    has_addr = (op == 2'b00) || (op == 2'b01);
    if (has_addr) begin
      cmd = {op, 5'($urandom), adr[16]};
      model_addr = adr;
    end else begin
      cmd = {op, 6'($urandom)};
    end
    it.we = (op[0] == 1'b0);
    it.adr = model_addr;
    it.dat = data;
    it.stall = stall;
    it.rdata = rdata;
    stall_cfg = stall;
    ack_cfg = ackd;
    rdata_cfg = rdata;
    exp_q.push_back(it);
    $display("txn op=%0d adr=%05h dat=%02h stall=%0d ackd=%0d rdata=%02h",
             op, model_addr, data, stall, ackd, rdata);
    model_addr = model_addr + 17'd1;
    send_byte(cmd);
    if (has_addr) begin
      send_byte(adr[15:8]);
      send_byte(adr[7:0]);
    end
    if (it.we) send_byte(data);
    if (do_wait) wait_idle();
  endtask

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", int'(wb_cyc_o), 0);
    chk("rst_stb", int'(wb_stb_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_adr", int'(wb_adr_o), 0);
    chk("rst_tx", int'(spi_tx_data_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Directed: WRITE_AT 01234 = 5A with two stall clocks, then READ_AT 1FFFF
    // and a READ_NEXT that wraps to 00000.
    start_frame();
    send_cmd(2'b00, 17'h01234, 8'h5A, 2, 0, 8'h00, 1);
    send_cmd(2'b01, 17'h1FFFF, 8'h00, 0, 1, 8'h77, 1);
    send_cmd(2'b11, 17'h00000, 8'h00, 1, 0, 8'h88, 1);
    end_frame(0);

    // Bytes arriving during a long bus cycle are dropped and flag overrun.
    start_frame();
    send_cmd(2'b11, 17'h00000, 8'h00, 20, 0, 8'h3C, 0);
    send_byte(8'h80);
    send_byte(8'hAA);
    wait_idle();
    end_frame(1);

    // A partial WRITE_AT is discarded; the next frame starts with a command.
    start_frame();
    send_byte(8'h00);
    send_byte(8'h12);
    end_frame(0);
    start_frame();
    send_cmd(2'b11, 17'h00000, 8'h00, 0, 0, 8'hC3, 1);
    end_frame(0);

    for (int f = 0; f < 4; f++) begin
      start_frame();
      n = 1 + int'($urandom_range(2, 0));
      for (int k = 0; k < n; k++) begin
        send_cmd(2'($urandom), 17'($urandom), 8'($urandom), int'($urandom_range(3, 0)),
                 int'($urandom_range(2, 0)), 8'($urandom), 1);
      end
      end_frame(0);
    end

    // Reset in the middle of a bus cycle clears everything at once.
    start_frame();
    send_cmd(2'b00, 17'h0ABCD, 8'hE7, 30, 0, 8'h00, 0);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("cyc_before_reset", int'(wb_cyc_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_cyc", int'(wb_cyc_o), 0);
    chk("arst_stb", int'(wb_stb_o), 0);
    chk("arst_we", int'(wb_we_o), 0);
    chk("arst_adr", int'(wb_adr_o), 0);
    chk("arst_dat", int'(wb_dat_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_tx", int'(spi_tx_data_o), 0);
    spi_cs_ni = 1'b1;
    model_addr = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    start_frame();
    send_cmd(2'b10, 17'h00000, 8'h5E, 1, 1, 8'h00, 1);
    send_cmd(2'b11, 17'h00000, 8'h00, 0, 2, 8'h9B, 1);
    end_frame(0);

    repeat (5) @(negedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spi_cmd.md
SPI_CMD -- requirements
Module: spi_cmd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, SPI byte and bus data width.
REQ-003 SHALL have port clk_i, input, 1, the one system clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port spi_cs_ni, input, 1, raw SPI chip select (async); high ends the frame.
REQ-006 SHALL have port spi_rx_data_i, input, DATA_WIDTH, received byte from the SPI shifter (SCK domain).
REQ-007 SHALL have port spi_rx_strobe_i, input, 1, SCK-domain byte-valid strobe from the SPI shifter (async).
REQ-008 SHALL have port spi_tx_data_o, output, DATA_WIDTH, next byte for the SPI shifter to transmit.
REQ-009 SHALL have port busy_o, input/output direction output, width 1, high while a bus cycle is pending.
REQ-010 SHALL have port overrun_o, output, 1, sticky flag: a byte arrived while busy.
REQ-011 SHALL have ports wb_cyc_o/wb_stb_o/wb_we_o (output, 1), wb_adr_o (output, ADDR_WIDTH) and wb_dat_o (output, DATA_WIDTH), the Wishbone master request.
REQ-012 SHALL have ports wb_dat_i (input, DATA_WIDTH) and wb_ack_i/wb_stall_i (input, 1), the Wishbone response.

Function
REQ-013 SHALL pass spi_cs_ni and spi_rx_strobe_i through 2-flop synchronizers, then detect the rising edge of the synchronized strobe to form a 1-clk byte_valid.
REQ-014 SHALL sample spi_rx_data_i on byte_valid; the system constraint is SCK period >= 4 clk_i, which keeps the data stable.
REQ-015 SHALL decode command byte [7:6] as op: 00 WRITE_AT, 01 READ_AT, 10 WRITE_NEXT, 11 READ_NEXT.
REQ-016 SHALL treat command byte bit [0] as address bit 16; bits [5:1] are reserved and ignored.
REQ-017 SHALL use these byte sequences: WRITE_AT = cmd, addr[15:8], addr[7:0], data; READ_AT = cmd, addr[15:8], addr[7:0]; WRITE_NEXT = cmd, data; READ_NEXT = cmd.
REQ-018 SHALL implement FSM states CMD, ADDR_HI, ADDR_LO, DATA, BUS; each byte_valid advances along the sequence for the op.
REQ-019 SHALL enter BUS on the final byte of a command and assert wb_cyc_o and wb_stb_o together on the next clk.
REQ-020 SHALL hold wb_stb_o while wb_stall_i=1, and drop wb_stb_o in the cycle after it is accepted (stb and !stall).
REQ-021 SHALL hold wb_cyc_o until wb_ack_i, and deassert it in the cycle after ack.
REQ-022 SHALL set wb_we_o=1 for WRITE ops and 0 for READ ops, with wb_dat_o equal to the received data byte.
REQ-023 SHALL load spi_tx_data_o from wb_dat_i on the read ack; write acks leave spi_tx_data_o unchanged.
REQ-024 SHALL increment the address register modulo 2^ADDR_WIDTH after every acked cycle (1FFFF -> 00000), and go BUS -> CMD.
REQ-025 SHALL assert busy_o from entry to BUS until the clk after ack.
REQ-026 SHALL ignore a byte_valid in BUS and set overrun_o, which stays set until the synchronized CS rises.
REQ-027 SHALL return the FSM to CMD when synchronized CS is high, from any state except BUS.
REQ-028 SHALL complete an in-flight BUS cycle normally when CS rises, then go to CMD.
REQ-029 SHALL discard a partially received command when CS rises; no bus cycle is issued.
REQ-030 SHALL process multiple commands back-to-back within one CS frame.

Reset
REQ-031 SHALL, while rst_ni=0, force state CMD, address 0, spi_tx_data_o 0, all wb_* outputs 0, busy_o 0 and overrun_o 0.
REQ-032 SHALL set the synchronizer flops to CS=1 and strobe=0 during reset.
REQ-033 SHALL abandon any bus cycle on reset, with no ack wait.

Structure
REQ-034 SHALL put the op enum, the state enum and the ADDR_WIDTH/DATA_WIDTH defaults in package spi_cmd_pkg.
REQ-035 SHALL instantiate sub-module sync2 (2-flop synchronizer with reset value parameter) once per async input.

Verification
REQ-036 SHALL cover WRITE_AT 00 12 34 5A with ack after 2 stall clks -> one cycle adr=01234, we=1, dat=5A, stb for 3 clks, address becomes 01235.
REQ-037 SHALL cover READ_AT 41 FF FF then READ_NEXT C0 with wb_dat_i=77 then 88 -> adr 1FFFF then 00000, spi_tx_data_o 77 then 88.
REQ-038 SHALL cover WRITE_NEXT 80 AA sent while busy -> AA ignored, overrun_o=1; CS rise clears overrun_o.
REQ-039 SHALL cover CS rising after 00 12 -> no bus cycle, and the next frame's first byte is decoded as cmd.
REQ-040 SHALL cover rst_ni low mid-BUS -> all outputs 0 immediately (async), state CMD.
